// File: rtl/res_pack_buffer.sv
`default_nettype none
// ============================================================================
// res_pack_buffer : ping-pong packer of lane0 fp32 results into per-lane words
// Revision 1.0
// ============================================================================
module res_pack_buffer #(
    parameter int unsigned NrLanes = 4,
    parameter int unsigned ElenW   = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       elem_valid_i,
    input  logic [ElenW-1:0]           elem_data_i,
    input  logic                       elem_last_i,
    output logic                       elem_ready_o,
    output logic [NrLanes-1:0]         stu_req_o,
    output logic [NrLanes*ElenW-1:0]   stu_wdata_o,
    input  logic [NrLanes-1:0]         stu_gnt_i,
    input  logic                       flush_i,
    output logic                       done_o
);

    localparam int unsigned NrSlots = 2 * NrLanes;
    localparam int unsigned CntW    = $clog2(NrSlots);
    localparam int unsigned WordW   = NrLanes * ElenW;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_e;

    bank_state_e               state_q [2];
    bank_state_e               state_d [2];
    logic [WordW-1:0]          data_q  [2];
    logic [WordW-1:0]          data_d  [2];
    logic [NrLanes-1:0]        sent_q  [2];
    logic [NrLanes-1:0]        sent_d  [2];
    logic [1:0]                last_q, last_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic                      wr_q, wr_d;
    logic                      rd_q, rd_d;
    logic                      done_q, done_d;
    logic                      accept;
    logic                      drain_done;
    logic [NrLanes-1:0]        sent_next;
    logic                      unused_hi;

    // Slots 0..NrLanes-1 fill the low halves, the rest fill the high halves.
    function automatic int slot_off(input int k);
        if (k < int'(NrLanes)) return k * int'(ElenW);
        return (k - int'(NrLanes)) * int'(ElenW) + 32;
    endfunction

    assign unused_hi    = ^elem_data_i[ElenW-1:32];

    assign elem_ready_o = rst_ni && (state_q[wr_q] != FULL) && !flush_i;
    assign accept       = elem_valid_i && elem_ready_o;
    assign stu_req_o    = (state_q[rd_q] == FULL) ? ~sent_q[rd_q] : '0;
    assign stu_wdata_o  = data_q[rd_q];
    assign sent_next    = sent_q[rd_q] | (stu_gnt_i & stu_req_o);
    assign drain_done   = (state_q[rd_q] == FULL) && (&sent_next);
    assign done_o       = done_q;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sent_d  = sent_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        done_d  = 1'b0;
        if (flush_i) begin
            for (int b = 0; b < 2; b++) begin
                state_d[b] = EMPTY;
                data_d[b]  = '0;
                sent_d[b]  = '0;
            end
            last_d = '0;
            cnt_d  = '0;
            wr_d   = 1'b0;
            rd_d   = 1'b0;
        end else begin
            // The fill bank is never FULL on accept, so it cannot be the bank draining.
            if (accept) begin
                for (int k = 0; k < int'(NrSlots); k++) begin
                    if (cnt_q == CntW'(k)) begin
                        data_d[wr_q][slot_off(k) +: 32] = elem_data_i[31:0];
                    end
                end
                state_d[wr_q] = FILLING;
                if ((cnt_q == CntW'(NrSlots - 1)) || elem_last_i) begin
                    state_d[wr_q] = FULL;
                    last_d[wr_q]  = elem_last_i;
                    cnt_d         = '0;
                    wr_d          = ~wr_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            if (state_q[rd_q] == FULL) begin
                sent_d[rd_q] = sent_next;
                if (drain_done) begin
                    state_d[rd_q] = EMPTY;
                    data_d[rd_q]  = '0;
                    sent_d[rd_q]  = '0;
                    last_d[rd_q]  = 1'b0;
                    rd_d          = ~rd_q;
                    done_d        = last_q[rd_q];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int b = 0; b < 2; b++) begin
                state_q[b] <= EMPTY;
                data_q[b]  <= '0;
                sent_q[b]  <= '0;
            end
            last_q <= '0;
            cnt_q  <= '0;
            wr_q   <= 1'b0;
            rd_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sent_q  <= sent_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            done_q  <= done_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_res_pack_buffer.sv
`default_nettype none
// tb_res_pack_buffer : directed vector table plus hand sequences for res_pack_buffer.
module tb_res_pack_buffer;

    logic         clk;
    logic         rst_ni;
    logic         elem_valid;
    logic [63:0]  elem_data;
    logic         elem_last;
    logic         elem_ready;
    logic [3:0]   stu_req;
    logic [255:0] stu_wdata;
    logic [3:0]   stu_gnt;
    logic         flush;
    logic         done;

    int n_vec = 0;
    int n_err = 0;

    res_pack_buffer #(.NrLanes(4), .ElenW(64)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .elem_valid_i (elem_valid),
        .elem_data_i  (elem_data),
        .elem_last_i  (elem_last),
        .elem_ready_o (elem_ready),
        .stu_req_o    (stu_req),
        .stu_wdata_o  (stu_wdata),
        .stu_gnt_i    (stu_gnt),
        .flush_i      (flush),
        .done_o       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic         valid;
        logic [31:0]  data;
        logic         last;
        logic [3:0]   gnt;
        logic         ready;
        logic [3:0]   req;
        logic         done;
        logic         chk_wd;
        logic [255:0] wd;
    } vec_t;

    vec_t           vt [17];
    logic [7:0][31:0] fp;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Slot k<4 -> lane k low half, k>=4 -> lane k-4 high half.
    function automatic logic [255:0] mkword(input logic [7:0][31:0] s);
        logic [255:0] w;
        w = '0;
        for (int k = 0; k < 8; k++) begin
            if (k < 4) w[k*64 +: 32] = s[k];
            else       w[(k-4)*64 + 32 +: 32] = s[k];
        end
        return w;
    endfunction

    function automatic logic [255:0] seqword(input int base, input int n);
        logic [7:0][31:0] s;
        s = '0;
        for (int k = 0; k < n; k++) s[k] = 32'(base + k);
        return mkword(s);
    endfunction

    function automatic vec_t mkv(input logic v, input logic [31:0] d, input logic l, input logic [3:0] g,
                                 input logic r, input logic [3:0] q, input logic dn,
                                 input logic cw, input logic [255:0] w);
        vec_t x;
        x.valid = v; x.data = d; x.last = l; x.gnt = g;
        x.ready = r; x.req = q; x.done = dn; x.chk_wd = cw; x.wd = w;
        return x;
    endfunction

    task automatic idle();
        elem_valid = 1'b0;
        elem_data  = '0;
        elem_last  = 1'b0;
        stu_gnt    = 4'h0;
        flush      = 1'b0;
    endtask

    // Push n elements back-to-back; upper 32 bits carry junk that must be ignored.
    task automatic push(input int base, input int n, input logic last_on_end, input logic [3:0] g);
        for (int i = 0; i < n; i++) begin
            elem_valid = 1'b1;
            elem_data  = {32'hDEADBEEF, 32'(base + i)};
            elem_last  = last_on_end && (i == n - 1);
            stu_gnt    = g;
            #1;
            chk("push_ready", 256'(elem_ready), 256'(1'b1));
            @(negedge clk);
        end
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0][31:0] s;
        logic [255:0]     w1, w2;
        logic [255:0]     got [$];
        int               acc;

        fp[0] = 32'h3F800000; fp[1] = 32'h40000000; fp[2] = 32'h40400000; fp[3] = 32'h40800000;
        fp[4] = 32'h40A00000; fp[5] = 32'h40C00000; fp[6] = 32'h40E00000; fp[7] = 32'h41000000;
        w1 = mkword(fp);
        s = '0; s[0] = fp[0]; s[1] = fp[1]; s[2] = fp[2];
        w2 = mkword(s);

        for (int i = 0; i < 8; i++)
            vt[i] = mkv(1'b1, fp[i], i == 7, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, '0);
        vt[8]  = mkv(1'b0, '0, 1'b0, 4'hF, 1'b1, 4'hF, 1'b0, 1'b1, w1);
        vt[9]  = mkv(1'b0, '0, 1'b0, 4'h0, 1'b1, 4'h0, 1'b1, 1'b1, '0);
        vt[10] = mkv(1'b0, '0, 1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++)
            vt[11+i] = mkv(1'b1, fp[i], i == 2, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, '0);
        vt[14] = mkv(1'b0, '0, 1'b0, 4'h0, 1'b1, 4'hF, 1'b0, 1'b1, w2);
        vt[15] = mkv(1'b0, '0, 1'b0, 4'hF, 1'b1, 4'hF, 1'b0, 1'b1, w2);
        vt[16] = mkv(1'b0, '0, 1'b0, 4'h0, 1'b1, 4'h0, 1'b1, 1'b1, '0);

        // Reset state
        idle();
        rst_ni = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_ready", 256'(elem_ready), 256'(1'b0));
        chk("rst_req",   256'(stu_req),    256'(4'h0));
        chk("rst_wdata", stu_wdata,        '0);
        chk("rst_done",  256'(done),       256'(1'b0));
        @(negedge clk);
        rst_ni = 1'b1;
        #1;
        chk("post_rst_ready", 256'(elem_ready), 256'(1'b1));

        // Full word with last, then a short 3-element word
        for (int i = 0; i < 17; i++) begin
            elem_valid = vt[i].valid;
            elem_data  = {32'hCAFEF00D, vt[i].data};
            elem_last  = vt[i].last;
            stu_gnt    = vt[i].gnt;
            #1;
            chk($sformatf("vec%0d_ready", i), 256'(elem_ready), 256'(vt[i].ready));
            chk($sformatf("vec%0d_req", i),   256'(stu_req),    256'(vt[i].req));
            chk($sformatf("vec%0d_done", i),  256'(done),       256'(vt[i].done));
            if (vt[i].chk_wd) chk($sformatf("vec%0d_wdata", i), stu_wdata, vt[i].wd);
            @(negedge clk);
        end
        idle();

        // Backpressure: 24 elements, no grants until cycle 20
        acc = 0;
        for (int c = 0; c < 200 && (acc < 24 || got.size() < 3); c++) begin
            if (acc < 24) begin
                elem_valid = 1'b1;
                elem_data  = {32'hDEADBEEF, 32'(1000 + acc)};
                elem_last  = (acc == 23);
            end else begin
                elem_valid = 1'b0;
                elem_last  = 1'b0;
            end
            stu_gnt = (c >= 20) ? 4'hF : 4'h0;
            #1;
            if (c >= 16 && c < 20) chk("bp_ready_low", 256'(elem_ready), 256'(1'b0));
            if (c == 16) chk("bp_accepts", 256'(acc), 256'(16));
            if (stu_req == 4'hF && stu_gnt == 4'hF) got.push_back(stu_wdata);
            if (elem_valid && elem_ready) acc++;
            @(negedge clk);
        end
        idle();
        chk("bp_words", 256'(got.size()), 256'(3));
        for (int w = 0; w < 3 && w < got.size(); w++)
            chk($sformatf("bp_word%0d", w), got[w], seqword(1000 + 8 * w, 8));
        @(negedge clk);

        // Staggered grants; grants during fill must be ignored
        push(2000, 8, 1'b0, 4'hF);
        #1;
        chk("stg_req_full", 256'(stu_req), 256'(4'hF));
        chk("stg_wd0", stu_wdata, seqword(2000, 8));
        @(negedge clk);
        stu_gnt = 4'b0100;
        @(negedge clk);
        stu_gnt = 4'h0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("stg_req_partial", 256'(stu_req), 256'(4'b1011));
            chk("stg_wd_stable", stu_wdata, seqword(2000, 8));
            @(negedge clk);
        end
        stu_gnt = 4'b1011;
        #1;
        chk("stg_req_last", 256'(stu_req), 256'(4'b1011));
        @(negedge clk);
        stu_gnt = 4'h0;
        #1;
        chk("stg_req_freed", 256'(stu_req), 256'(4'h0));
        chk("stg_wd_freed", stu_wdata, '0);
        @(negedge clk);
        #1;
        chk("stg_no_done", 256'(done), 256'(1'b0));
        @(negedge clk);

        // Flush with one bank FULL and the other at cnt=5
        push(3000, 8, 1'b0, 4'h0);
        push(4000, 5, 1'b0, 4'h0);
        elem_valid = 1'b1;
        elem_data  = 64'h0000_0000_0BAD_0BAD;
        flush      = 1'b1;
        #1;
        chk("fl_ready_gated", 256'(elem_ready), 256'(1'b0));
        chk("fl_req_before", 256'(stu_req), 256'(4'hF));
        @(negedge clk);
        idle();
        #1;
        chk("fl_req", 256'(stu_req), 256'(4'h0));
        chk("fl_ready", 256'(elem_ready), 256'(1'b1));
        chk("fl_done", 256'(done), 256'(1'b0));
        chk("fl_wd", stu_wdata, '0);
        @(negedge clk);
        push(5000, 1, 1'b1, 4'h0);
        #1;
        chk("fl_done2", 256'(done), 256'(1'b0));
        chk("fl_new_req", 256'(stu_req), 256'(4'hF));
        chk("fl_slot0", stu_wdata, seqword(5000, 1));
        stu_gnt = 4'hF;
        @(negedge clk);
        stu_gnt = 4'h0;
        #1;
        chk("fl_last_done", 256'(done), 256'(1'b1));
        @(negedge clk);

        // Asynchronous reset mid-drain
        push(6000, 8, 1'b1, 4'h0);
        stu_gnt = 4'b0001;
        @(negedge clk);
        stu_gnt = 4'h0;
        #1;
        chk("ar_req_partial", 256'(stu_req), 256'(4'b1110));
        #1;
        rst_ni = 1'b0;
        #1;
        chk("ar_ready", 256'(elem_ready), 256'(1'b0));
        chk("ar_req",   256'(stu_req),    256'(4'h0));
        chk("ar_wd",    stu_wdata,        '0);
        chk("ar_done",  256'(done),       256'(1'b0));
        @(negedge clk);
        rst_ni = 1'b1;
        #1;
        chk("ar_rel_ready", 256'(elem_ready), 256'(1'b1));
        chk("ar_rel_req",   256'(stu_req),    256'(4'h0));
        @(negedge clk);
        #1;
        chk("ar_rel_req2",  256'(stu_req),    256'(4'h0));
        chk("ar_rel_wd",    stu_wdata,        '0);
        chk("ar_rel_done",  256'(done),       256'(1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/res_pack_buffer.md
RES_PACK_BUFFER -- requirements
Module: res_pack_buffer

Interface
REQ-001 SHALL have parameter NrLanes, default 4: number of lanes; one packed word = 2*NrLanes fp32 elements.
REQ-002 SHALL have parameter ElenW, default 64: per-lane data width; only fp32 payload in bits [31:0] of each input element is used.
REQ-003 SHALL have port clk_i  input  1  clock, rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port elem_valid_i  input  1  lane0 result element valid.
REQ-006 SHALL have port elem_data_i  input  ElenW  lane0 result element; fp32 in [31:0].
REQ-007 SHALL have port elem_last_i  input  1  marks the final element of the vector, qualified by elem_valid_i.
REQ-008 SHALL have port elem_ready_o  output  1  element accepted when elem_valid_i and elem_ready_o are both high.
REQ-009 SHALL have port stu_req_o  output  NrLanes  per-lane store-unit request.
REQ-010 SHALL have port stu_wdata_o  output  NrLanes*ElenW  per-lane packed data.
REQ-011 SHALL have port stu_gnt_i  input  NrLanes  per-lane store-unit grant, one-cycle pulse per accepted beat.
REQ-012 SHALL have port flush_i  input  1  synchronous abort; clears all state.
REQ-013 SHALL have port done_o  output  1  one-cycle pulse when the word holding the last element is fully granted.

Function
REQ-014 SHALL contain two banks, each with NrLanes*ElenW data bits, a per-bank state (EMPTY, FILLING, FULL), a per-bank last flag, and a per-lane sent mask.
REQ-015 SHALL keep a fill pointer wr_q and a drain pointer rd_q, both 1 bit, both 0 after reset; banks alternate ping-pong.
REQ-016 SHALL pack element index k, with 0<=k<2*NrLanes, as: k<NrLanes -> lane k bits [31:0]; k>=NrLanes -> lane k-NrLanes bits [63:32].
REQ-017 SHALL count elements in the fill bank with an index counter cnt_q, width $clog2(2*NrLanes), reset 0.
REQ-018 SHALL drive elem_ready_o = bank[wr_q] not FULL and flush_i low.
REQ-019 SHALL, on an element accept, write the element to slot cnt_q and set bank[wr_q] to FILLING.
REQ-020 SHALL, on an accept with cnt_q = 2*NrLanes-1 or elem_last_i high, set bank[wr_q] to FULL, store elem_last_i in its last flag, reset cnt_q to 0, and toggle wr_q.
REQ-021 SHALL zero the unwritten slots of a bank closed by elem_last_i; a bank SHALL be cleared to zero whenever it enters EMPTY.
REQ-022 SHALL drive stu_req_o[i] = bank[rd_q] FULL and sent[i] low; stu_wdata_o SHALL equal bank[rd_q] data, stable while any request is high.
REQ-023 SHALL set sent[i] on stu_gnt_i[i] while stu_req_o[i] is high; grants on lanes not requesting SHALL be ignored.
REQ-024 SHALL, in the cycle where the final outstanding lane is granted, set bank[rd_q] to EMPTY, clear its sent mask, toggle rd_q, and pulse done_o one cycle later if the bank's last flag was set.
REQ-025 SHALL allow a drain completion of one bank and an element accept into the other bank in the same cycle, with no lost beat.
REQ-026 SHALL allow an accept into a bank that drains to EMPTY in the same cycle only from the next cycle; elem_ready_o uses registered state.
REQ-027 SHALL accept elements with zero bubbles while the fill bank is not FULL; sustained throughput SHALL be 1 element/cycle.
REQ-028 SHALL, with both banks FULL, hold elem_ready_o low until a drain completes.
REQ-029 SHALL, on flush_i, return both banks to EMPTY with zeroed data, clear cnt_q, wr_q, rd_q and the sent masks, drop all stu_req_o the next cycle, and not pulse done_o.
REQ-030 SHALL treat elem_last_i on the 2*NrLanes-th element as a single full word; no empty extra word SHALL be emitted.

Reset
REQ-031 SHALL, while rst_ni is low, hold elem_ready_o=0, stu_req_o=0, stu_wdata_o=0, done_o=0, with all banks EMPTY and all pointers and counters at 0.
REQ-032 SHALL, after reset is released, assert elem_ready_o=1 in the first cycle; reset asserted mid-transfer SHALL discard all buffered data.

Verification
REQ-033 SHALL test: NrLanes=4, elements 1.0..8.0 with the 8th tagged last, stu_gnt_i=4'hF immediately -> lane0 = {5.0,1.0}, lane3 = {8.0,4.0}, done_o pulses once.
REQ-034 SHALL test: 3 elements, last on the 3rd -> lanes 0-2 low halves carry the data, all other slots 0, stu_req_o=4'hF.
REQ-035 SHALL test: 24 back-to-back elements with stu_gnt_i held 0 -> elem_ready_o drops after the 16th accept; grants resume the flow; 3 words delivered in order.
REQ-036 SHALL test: staggered grants (lane2 first, others 5 cycles later) -> stu_req_o[2] drops alone, the bank frees only after the last grant, data stays stable throughout.
REQ-037 SHALL test: flush_i mid-fill (cnt=5) with one bank FULL -> next cycle stu_req_o=0, elem_ready_o=1, the next word starts at slot 0, done_o stays 0.
REQ-038 SHALL test: rst_ni pulsed low mid-drain -> all outputs are 0 asynchronously, with no stale request after release.
